// File: rtl/color_pkg.sv
// Shared pixel-format definitions for the framebuffer colour path: channel
// field widths per packed pixel width and left-aligned widening to 8 bits.
package color_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // A width of 0 marks an unsupported packed pixel width.
    function automatic int r_bits(input int w);
        case (w)
            8:       return 3;
            12:      return 4;
            16:      return 5;
            24:      return 8;
            default: return 0;
        endcase
    endfunction

    function automatic int g_bits(input int w);
        case (w)
            8:       return 3;
            12:      return 4;
            16:      return 6;
            24:      return 8;
            default: return 0;
        endcase
    endfunction

    function automatic int b_bits(input int w);
        case (w)
            8:       return 2;
            12:      return 4;
            16:      return 5;
            24:      return 8;
            default: return 0;
        endcase
    endfunction

    // field holds nbits valid bits in its LSBs; they move to the MSBs, zeros below.
    function automatic logic [7:0] expand_to_8(input logic [7:0] field, input int nbits);
        logic [7:0] res;
        res = field << (8 - nbits);
        return res;
    endfunction

endpackage

// File: rtl/fbuf_color_converter_if.sv
// Pixel bus between framebuffer read data and the colour converter output.
interface fbuf_color_converter_if #(
    parameter int FBUF_DATA_WIDTH = 8
);
    // No handshake: a new pixel is taken every cycle, the result follows one cycle later.
    logic [FBUF_DATA_WIDTH-1:0] in_color;
    logic [23:0]                out_color;

    modport master (output in_color, input out_color);
    modport slave  (input in_color, output out_color);
endinterface

// File: rtl/fbuf_color_converter_expand.sv
// Combinational widening of one colour channel field to 8 bits (left-aligned, zero-filled).
module color_channel_expand
    import color_pkg::*;
#(
    parameter int IN_BITS = 3
) (
    input  logic [IN_BITS-1:0] field,
    output logic [7:0]         expanded
);

    assign expanded = expand_to_8(8'(field), IN_BITS);

endmodule

// File: rtl/fbuf_color_converter.sv
// Expands a packed RGB332/444/565/888 framebuffer pixel to registered RGB888,
// optionally emitting the channels in R,B,G order.
module fbuf_color_converter
    import color_pkg::*;
#(
    parameter int FBUF_DATA_WIDTH   = 8,
    parameter bit SWITCH_RGB_TO_RBG = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    fbuf_color_converter_if.slave pix
);

    localparam int RB = r_bits(FBUF_DATA_WIDTH);
    localparam int GB = g_bits(FBUF_DATA_WIDTH);
    localparam int BB = b_bits(FBUF_DATA_WIDTH);

    generate
        if (RB == 0) begin : g_illegal
            $error("fbuf_color_converter: FBUF_DATA_WIDTH=%0d unsupported (use 8, 12, 16 or 24)",
                   FBUF_DATA_WIDTH);
            assign pix.out_color = '0;
        end else begin : g_conv
            logic [RB-1:0] r_field;
            logic [GB-1:0] g_field;
            logic [BB-1:0] b_field;
            logic [7:0]    r8;
            logic [7:0]    g8;
            logic [7:0]    b8;
            rgb888_t       mapped;
            rgb888_t       out_q;

            assign r_field = pix.in_color[FBUF_DATA_WIDTH-1 -: RB];
            assign g_field = pix.in_color[BB+GB-1 -: GB];
            assign b_field = pix.in_color[BB-1:0];

            color_channel_expand #(.IN_BITS(RB)) u_r (.field(r_field), .expanded(r8));
            color_channel_expand #(.IN_BITS(GB)) u_g (.field(g_field), .expanded(g8));
            color_channel_expand #(.IN_BITS(BB)) u_b (.field(b_field), .expanded(b8));

            // The struct names are output lanes: in RBG mode lane g carries blue, lane b green.
            always_comb begin
                mapped   = '0;
                mapped.r = r8;
                mapped.g = SWITCH_RGB_TO_RBG ? b8 : g8;
                mapped.b = SWITCH_RGB_TO_RBG ? g8 : b8;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    out_q <= '0;
                end else begin
                    out_q <= mapped;
                end
            end

            assign pix.out_color = out_q;
        end
    endgenerate

endmodule

// File: tb/tb_fbuf_color_converter.sv
// Bench for fbuf_color_converter: 8-bit pixels in both channel orders side by side,
// plus 12/16/24-bit instances exercised with random pixels against a reference model.
module tb_fbuf_color_converter;

    logic clk;
    logic reset;

    int n_checks;
    int n_pass;

    fbuf_color_converter_if #(.FBUF_DATA_WIDTH(8))  if8_s0 ();
    fbuf_color_converter_if #(.FBUF_DATA_WIDTH(8))  if8_s1 ();
    fbuf_color_converter_if #(.FBUF_DATA_WIDTH(12)) if12_s1 ();
    fbuf_color_converter_if #(.FBUF_DATA_WIDTH(16)) if16_s0 ();
    fbuf_color_converter_if #(.FBUF_DATA_WIDTH(24)) if24_s1 ();

    fbuf_color_converter #(.FBUF_DATA_WIDTH(8),  .SWITCH_RGB_TO_RBG(1'b0)) u8_s0 (
        .clk(clk), .reset(reset), .pix(if8_s0.slave));
    fbuf_color_converter #(.FBUF_DATA_WIDTH(8),  .SWITCH_RGB_TO_RBG(1'b1)) u8_s1 (
        .clk(clk), .reset(reset), .pix(if8_s1.slave));
    fbuf_color_converter #(.FBUF_DATA_WIDTH(12), .SWITCH_RGB_TO_RBG(1'b1)) u12_s1 (
        .clk(clk), .reset(reset), .pix(if12_s1.slave));
    fbuf_color_converter #(.FBUF_DATA_WIDTH(16), .SWITCH_RGB_TO_RBG(1'b0)) u16_s0 (
        .clk(clk), .reset(reset), .pix(if16_s0.slave));
    fbuf_color_converter #(.FBUF_DATA_WIDTH(24), .SWITCH_RGB_TO_RBG(1'b1)) u24_s1 (
        .clk(clk), .reset(reset), .pix(if24_s1.slave));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [23:0] model(input int w, input bit sw, input logic [23:0] px);
        int rb, gb, bb, p, r, g, b;
        case (w)
            8:       begin rb = 3; gb = 3; bb = 2; end
            12:      begin rb = 4; gb = 4; bb = 4; end
            16:      begin rb = 5; gb = 6; bb = 5; end
            default: begin rb = 8; gb = 8; bb = 8; end
        endcase
        p = int'(px);
        b = p % (1 << bb);
        g = (p / (1 << bb)) % (1 << gb);
        r = (p / (1 << (bb + gb))) % (1 << rb);
        r = r * (1 << (8 - rb));
        g = g * (1 << (8 - gb));
        b = b * (1 << (8 - bb));
        return sw ? {8'(r), 8'(b), 8'(g)} : {8'(r), 8'(g), 8'(b)};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %06h expected %06h", name, act, exp);
    endtask

    task automatic check_all(input string name, input logic [23:0] e8_s0, input logic [23:0] e8_s1,
                             input logic [23:0] e12, input logic [23:0] e16, input logic [23:0] e24);
        check({name, " w8_s0"},  if8_s0.out_color,  e8_s0);
        check({name, " w8_s1"},  if8_s1.out_color,  e8_s1);
        check({name, " w12_s1"}, if12_s1.out_color, e12);
        check({name, " w16_s0"}, if16_s0.out_color, e16);
        check({name, " w24_s1"}, if24_s1.out_color, e24);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [7:0] v8, input logic [11:0] v12,
                         input logic [15:0] v16, input logic [23:0] v24);
        if8_s0.in_color  = v8;
        if8_s1.in_color  = v8;
        if12_s1.in_color = v12;
        if16_s0.in_color = v16;
        if24_s1.in_color = v24;
    endtask

    typedef struct {
        logic [7:0]  in8;
        logic [23:0] exp_s0;
        logic [23:0] exp_s1;
    } vec_t;

    vec_t vecs[7];
    logic [23:0] exp_q[$];

    initial begin
        logic [7:0]  r8;
        logic [11:0] r12;
        logic [15:0] r16;
        logic [23:0] r24;
        n_checks = 0;
        n_pass   = 0;

        vecs[0] = '{8'h00, 24'h000000, 24'h000000};
        vecs[1] = '{8'hE0, 24'hE00000, 24'hE00000};
        vecs[2] = '{8'h1C, 24'h00E000, 24'h0000E0};
        vecs[3] = '{8'h03, 24'h0000C0, 24'h00C000};
        vecs[4] = '{8'hFF, 24'hE0E0C0, 24'hE0C0E0};
        vecs[5] = '{8'h92, 24'h808080, 24'h808080};
        vecs[6] = '{8'h49, 24'h404040, 24'h404040};

        // Reset state, no clock edge seen yet
        reset = 1'b1;
        drive(8'h00, 12'h000, 16'h0000, 24'h000000);
        #1;
        check_all("reset", 24'h0, 24'h0, 24'h0, 24'h0, 24'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("post_reset_zero", 24'h0, 24'h0, 24'h0, 24'h0, 24'h0);

        // Table-driven 8-bit vectors, both channel orders
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(vecs[i].in8, 12'h000, 16'h0000, 24'h000000);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d w8_s0", i), if8_s0.out_color, vecs[i].exp_s0);
            check($sformatf("vec%0d w8_s1", i), if8_s1.out_color, vecs[i].exp_s1);
        end

        // 16-bit boundary pixels
        @(negedge clk);
        drive(8'h00, 12'h000, 16'hFFFF, 24'h000000);
        @(posedge clk);
        #1;
        check("w16 ffff", if16_s0.out_color, 24'hF8FCF8);
        @(negedge clk);
        drive(8'h00, 12'h000, 16'h07E0, 24'h000000);
        @(posedge clk);
        #1;
        check("w16 07e0", if16_s0.out_color, 24'h00FC00);

        // Mid-cycle input change must not reach the output before the next edge
        @(negedge clk);
        drive(8'hE0, 12'h000, 16'h0000, 24'h000000);
        @(posedge clk);
        #1;
        check("lat_first w8_s0", if8_s0.out_color, 24'hE00000);
        @(negedge clk);
        drive(8'h1C, 12'h000, 16'h0000, 24'h000000);
        #1;
        check("lat_hold w8_s0", if8_s0.out_color, 24'hE00000);
        check("lat_hold w8_s1", if8_s1.out_color, 24'hE00000);
        @(posedge clk);
        #1;
        check("lat_next w8_s0", if8_s0.out_color, 24'h00E000);
        check("lat_next w8_s1", if8_s1.out_color, 24'h0000E0);

        // Async reset mid-stream, then recovery on the first edge after release
        @(negedge clk);
        drive(8'hFF, 12'hFFF, 16'hFFFF, 24'hFFFFFF);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", 24'h0, 24'h0, 24'h0, 24'h0, 24'h0);
        @(posedge clk);
        #1;
        check_all("reset_hold", 24'h0, 24'h0, 24'h0, 24'h0, 24'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all("release_no_edge", 24'h0, 24'h0, 24'h0, 24'h0, 24'h0);
        @(posedge clk);
        #1;
        check_all("recover", 24'hE0E0C0, 24'hE0C0E0, 24'hF0F0F0, 24'hF8FCF8, 24'hFFFFFF);

        // Random pixels on every instance against the model
        for (int n = 0; n < 200; n++) begin
            r8  = 8'($urandom_range(0, 255));
            r12 = 12'($urandom_range(0, 4095));
            r16 = 16'($urandom_range(0, 65535));
            r24 = 24'($urandom);
            @(negedge clk);
            drive(r8, r12, r16, r24);
            exp_q.push_back(model(8,  1'b0, 24'(r8)));
            exp_q.push_back(model(8,  1'b1, 24'(r8)));
            exp_q.push_back(model(12, 1'b1, 24'(r12)));
            exp_q.push_back(model(16, 1'b0, 24'(r16)));
            exp_q.push_back(model(24, 1'b1, r24));
            @(posedge clk);
            #1;
            check("rand w8_s0",  if8_s0.out_color,  exp_q.pop_front());
            check("rand w8_s1",  if8_s1.out_color,  exp_q.pop_front());
            check("rand w12_s1", if12_s1.out_color, exp_q.pop_front());
            check("rand w16_s0", if16_s0.out_color, exp_q.pop_front());
            check("rand w24_s1", if24_s1.out_color, exp_q.pop_front());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
